// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: command and response handshake bundle for alu_op_issuer.
//   cmd_*  : tagged ALU command, valid/ready (master drives, slave accepts).
//   rsp_*  : tagged in-order response, valid/ready (slave drives, master accepts).
// Modports: master = sequencer/test front end, slave = alu_op_issuer.
interface alu_op_issuer_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic [4:0]       cmd_shamt;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_illegal
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shamt, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_illegal
  );
endinterface

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command-side driver for an external combinational ALU.
//   Buffers tagged commands in a DEPTH-entry FIFO, issues one at a time on
//   the registered alu_* outputs, waits SETTLE_CYC cycles, captures
//   alu_result/alu_carryFlag and returns an in-order tagged response.
//   Opcodes above MAX_OP never reach the ALU; they return result=0,
//   carry=0, illegal=1.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus (slave)      cmd_* valid/ready in, rsp_* valid/ready out
//   alu_opcode/input1/input2/shiftValue   registered ALU drive
//   alu_result/alu_carryFlag              ALU outputs sampled at capture
//   stat_ops/stat_illegal  saturating handshake counters, present only
//                    when ALU_ISSUER_STATS_EN is defined
module alu_op_issuer #(
  parameter int W          = 16,
  parameter int TAG_W      = 4,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_OP     = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_issuer_if.slave      bus,
  output logic [3:0]          alu_opcode,
  output logic [W-1:0]        alu_input1,
  output logic [W-1:0]        alu_input2,
  output logic [4:0]          alu_shiftValue,
  input  logic [W-1:0]        alu_result,
  input  logic                alu_carryFlag
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [7:0]          stat_illegal
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [3:0]  MAXOP = 4'(MAX_OP);

  typedef struct packed {
    logic [3:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [4:0]       sh;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             push, pop;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             rsp_valid_q, rsp_carry_q, rsp_ill_q;
  logic [W-1:0]     rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // Ready depends on the registered count only: a pop in the same cycle
  // does not open a slot for a push.
  assign bus.cmd_ready = (count < FULL);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = mem[rptr];

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_carry   = rsp_carry_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_illegal = rsp_ill_q;

  // Storage needs no reset; emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{op: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b,
                             sh: bus.cmd_shamt, tag: bus.cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_tag_q      <= '0;
      rsp_ill_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          if (head.op > MAXOP) begin
            // Rejected opcode: ALU drive keeps the last legal command.
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_ill_q    <= 1'b1;
            rsp_tag_q    <= head.tag;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
          end else begin
            alu_opcode     <= head.op;
            alu_input1     <= head.a;
            alu_input2     <= head.b;
            alu_shiftValue <= head.sh;
            rsp_tag_q      <= head.tag;
            cnt            <= CW'(SETTLE_CYC - 1);
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_result_q <= alu_result;
            rsp_carry_q  <= alu_carryFlag;
            rsp_ill_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid_q & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops     <= '0;
      stat_illegal <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != '1)                stat_ops     <= stat_ops + 1'b1;
      if (rsp_ill_q && stat_illegal != '1) stat_illegal <= stat_illegal + 1'b1;
    end
  end
`endif

endmodule
